// File: rtl/basic_system_ram_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM: splits burst
// reads/writes into one RAM access per cycle and returns read data in order.
module basic_system_ram_burst_adapter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BURST_W      = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     s_address,
    input  logic [BURST_W-1:0]    s_burstcount,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [DATA_W-1:0]     s_writedata,
    input  logic [DATA_W/8-1:0]   s_byteenable,
    output logic                  s_waitrequest,
    output logic [DATA_W-1:0]     s_readdata,
    output logic                  s_readdatavalid,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [BURST_W-1:0]      remaining;
    logic [BURST_W-1:0]      remaining_nxt;
    logic [BURST_W-1:0]      first_len;
    logic                    rd_issue;
    logic [READ_LATENCY-1:0] rd_pipe;

    // A burstcount of zero behaves as a single beat
    assign first_len = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_address     = addr;
        rd_issue      = 1'b0;
        s_waitrequest = 1'b0;

        case (state)
            IDLE: begin
                // Write takes priority if a master illegally raises both
                if (s_write) begin
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_address    = s_address;
                    if (first_len != BURST_W'(1)) begin
                        addr_nxt      = s_address + ADDR_W'(1);
                        remaining_nxt = first_len - BURST_W'(1);
                        state_nxt     = WR_BURST;
                    end
                end else if (s_read) begin
                    m_chipselect = 1'b1;
                    m_address    = s_address;
                    rd_issue     = 1'b1;
                    if (first_len != BURST_W'(1)) begin
                        addr_nxt      = s_address + ADDR_W'(1);
                        remaining_nxt = first_len - BURST_W'(1);
                        state_nxt     = RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (s_write) begin
                    m_chipselect  = 1'b1;
                    m_write       = 1'b1;
                    addr_nxt      = addr + ADDR_W'(1);
                    remaining_nxt = remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD_BURST: begin
                s_waitrequest = 1'b1;
                m_chipselect  = 1'b1;
                rd_issue      = 1'b1;
                addr_nxt      = addr + ADDR_W'(1);
                remaining_nxt = remaining - BURST_W'(1);
                if (remaining == BURST_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // No RAM traffic and no command acceptance while reset is held
        if (reset) begin
            m_chipselect  = 1'b0;
            m_write       = 1'b0;
            rd_issue      = 1'b0;
            s_waitrequest = 1'b1;
        end
    end

    // Issue strobes delayed to line up with the RAM read latency
    if (READ_LATENCY > 1) begin : g_rd_pipe_deep
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_pipe <= '0;
            end else begin
                rd_pipe <= {rd_pipe[READ_LATENCY-2:0], rd_issue};
            end
        end
    end else begin : g_rd_pipe_single
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_pipe <= '0;
            end else begin
                rd_pipe <= rd_issue;
            end
        end
    end

    assign s_readdatavalid = rd_pipe[READ_LATENCY-1] & ~reset;
    assign s_readdata      = m_readdata;
    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign m_clken         = 1'b1;

endmodule

// File: tb/tb_basic_system_ram_burst_adapter.sv
// Bench for basic_system_ram_burst_adapter: directed and random bursts against
// a word-array memory model with expected write and read-return queues.
module tb_basic_system_ram_burst_adapter;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   s_address;
    logic [BURST_W-1:0]  s_burstcount;
    logic                s_read;
    logic                s_write;
    logic [DATA_W-1:0]   s_writedata;
    logic [BE_W-1:0]     s_byteenable;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;
    logic                s_readdatavalid;
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [BE_W-1:0]     m_byteenable;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    basic_system_ram_burst_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
    } wr_ev_t;

    typedef struct packed {
        int unsigned       c;
        logic [DATA_W-1:0] d;
    } rv_t;

    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ram_init_done = 1'b0;
    wr_ev_t            wlog[$];
    wr_ev_t            wexp[$];
    rv_t               rvq[$];
    rv_t               rexp[$];
    int unsigned       rissue = 0;
    logic [DATA_W-1:0] wd[$];
    logic [BE_W-1:0]   wb[$];

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    // Single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else if (m_chipselect && m_clken) begin
            if (m_write) begin
                for (int b = 0; b < int'(BE_W); b++)
                    if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
            end else begin
                m_readdata <= ram[m_address];
            end
        end
    end

    always @(negedge clk) begin
        if (m_chipselect && m_write) wlog.push_back('{a: m_address, d: m_writedata, be: m_byteenable});
        if (m_chipselect && !m_write) rissue <= rissue + 1;
        if (s_readdatavalid) rvq.push_back('{c: cyc, d: s_readdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Write burst of len beats (0 means 1) from wd/wb; gaps between beats
    task automatic wr_burst(input string tag, input logic [ADDR_W-1:0] a, input int len,
                            input int gmin, input int gmax);
        int n;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0] be;
        n = (len == 0) ? 1 : len;
        s_read = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                s_write = 1'b0;
                s_address = ADDR_W'($urandom);
                repeat ($urandom_range(gmax, gmin)) tick();
            end
            d  = wd.pop_front();
            be = wb.pop_front();
            s_write      = 1'b1;
            s_address    = (k == 0) ? a : ADDR_W'($urandom);
            s_burstcount = (k == 0) ? BURST_W'(len) : BURST_W'($urandom);
            s_writedata  = d;
            s_byteenable = be;
            ea = a + ADDR_W'(k);
            for (int b = 0; b < int'(BE_W); b++)
                if (be[b]) ref_mem[ea][8*b +: 8] = d[8*b +: 8];
            wexp.push_back('{a: ea, d: d, be: be});
            tick();
        end
        s_write = 1'b0;
        tick();
        check({tag, "_wr_count"}, wlog.size(), wexp.size());
        for (int i = 0; i < wlog.size() && i < wexp.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(wlog[i].a), 32'(wexp[i].a));
            check({tag, "_wr_data"}, wlog[i].d, wexp[i].d);
            check({tag, "_wr_be"}, 32'(wlog[i].be), 32'(wexp[i].be));
        end
        wlog.delete();
        wexp.delete();
    endtask

    // Issue a read burst; returns as soon as a new command may be presented
    task automatic rd_burst(input string tag, input logic [ADDR_W-1:0] a, input int len);
        int n;
        int wh;
        int unsigned c0;
        n = (len == 0) ? 1 : len;
        check({tag, "_idle_wait"}, 32'(s_waitrequest), 32'd0);
        s_write      = 1'b0;
        s_read       = 1'b1;
        s_address    = a;
        s_burstcount = BURST_W'(len);
        c0 = cyc;
        for (int k = 0; k < n; k++)
            rexp.push_back('{c: c0 + 32'(k) + 1, d: ref_mem[a + ADDR_W'(k)]});
        tick();
        s_read    = 1'b0;
        s_address = ADDR_W'($urandom);
        wh = 0;
        while (s_waitrequest && wh < 40) begin
            wh++;
            tick();
        end
        check({tag, "_wait_cycles"}, 32'(wh), 32'(n - 1));
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (rvq.size() < rexp.size() && guard < 100) begin
            guard++;
            tick();
        end
        repeat (3) tick();
        check({tag, "_beats"}, rvq.size(), rexp.size());
        for (int i = 0; i < rvq.size() && i < rexp.size(); i++) begin
            check({tag, "_beat_cycle"}, rvq[i].c, rexp[i].c);
            check({tag, "_beat_data"}, rvq[i].d, rexp[i].d);
        end
        rvq.delete();
        rexp.delete();
    endtask

    initial begin
        int unsigned rc;
        int pre;
        int post;
        int len;
        logic [ADDR_W-1:0] a;

        reset = 1'b1;
        s_address = '0;
        s_burstcount = '0;
        s_read = 1'b0;
        s_write = 1'b0;
        s_writedata = '0;
        s_byteenable = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);

        // T1: reset behaviour
        repeat (3) @(posedge clk);
        #1;
        check("T1_wait_in_reset", 32'(s_waitrequest), 32'd1);
        check("T1_valid_in_reset", 32'(s_readdatavalid), 32'd0);
        check("T1_cs_in_reset", 32'(m_chipselect), 32'd0);
        reset = 1'b0;
        tick();
        check("T1_wait_after_release", 32'(s_waitrequest), 32'd0);
        check("T1_clken", 32'(m_clken), 32'd1);
        reset = 1'b1;
        #1;
        check("T1_wait_mid_idle_reset", 32'(s_waitrequest), 32'd1);
        check("T1_valid_mid_idle_reset", 32'(s_readdatavalid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("T1_wait_idle", 32'(s_waitrequest), 32'd0);
        wlog.delete();
        rvq.delete();

        // T2: single write then single read
        wd.push_back(32'hDEAD_BEEF);
        wb.push_back(4'hF);
        wr_burst("T2", 10'h005, 1, 0, 0);
        rd_burst("T2_rd", 10'h005, 1);
        drain("T2_rd");

        // T3: bursts wrapping at the top of the address space
        for (int k = 1; k <= 4; k++) begin
            wd.push_back(32'(k));
            wb.push_back(4'hF);
        end
        wr_burst("T3", 10'h3FE, 4, 0, 0);
        rd_burst("T3_rd", 10'h3FE, 4);
        drain("T3_rd");

        // T4: write gaps and partial byte enables
        for (int k = 0; k < 3; k++) begin
            wd.push_back(32'hC0DE_0000 + 32'(k));
            wb.push_back(4'hF);
        end
        wr_burst("T4_gap", 10'h040, 3, 2, 2);
        wd.push_back(32'h1234_5678);
        wb.push_back(4'hF);
        wr_burst("T4_full", 10'h020, 1, 0, 0);
        wd.push_back(32'h0000_AAAA);
        wb.push_back(4'h3);
        wr_burst("T4_part", 10'h020, 1, 0, 0);
        rd_burst("T4_rd", 10'h020, 1);
        drain("T4_rd");
        rd_burst("T4_rdgap", 10'h040, 3);
        drain("T4_rdgap");

        // T5: reset during a read burst, after three RAM reads
        rissue = 0;
        s_read = 1'b1;
        s_address = 10'h010;
        s_burstcount = BURST_W'(8);
        tick();
        s_read = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        rc = cyc;
        #1;
        check("T5_wait_in_reset", 32'(s_waitrequest), 32'd1);
        check("T5_valid_in_reset", 32'(s_readdatavalid), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("T5_read_issues", rissue, 32'd3);
        pre = 0;
        post = 0;
        foreach (rvq[i]) begin
            if (rvq[i].c < rc) begin
                check("T5_pre_reset_data", rvq[i].d, ref_mem[10'h010 + ADDR_W'(pre)]);
                pre++;
            end else begin
                post++;
            end
        end
        check("T5_pre_reset_beats", 32'(pre), 32'd2);
        check("T5_post_reset_beats", 32'(post), 32'd0);
        check("T5_idle_after_reset", 32'(s_waitrequest), 32'd0);
        rvq.delete();
        wlog.delete();
        rd_burst("T5_len0", 10'h030, 0);
        drain("T5_len0");

        // Random mix; reads are sometimes left in flight before the next command
        for (int it = 0; it < 40; it++) begin
            a   = ADDR_W'($urandom);
            len = $urandom_range(15, 0);
            case ($urandom_range(2, 0))
                0: begin
                    for (int k = 0; k < ((len == 0) ? 1 : len); k++) begin
                        wd.push_back($urandom);
                        wb.push_back(BE_W'($urandom));
                    end
                    wr_burst("RND", a, len, 0, 2);
                end
                1: rd_burst("RND_rd", a, len);
                default: begin
                    rd_burst("RND_rd", a, len);
                    drain("RND_rd");
                end
            endcase
        end
        drain("RND_final");

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
